// File: rtl/pwm_symbol_sequencer.sv
// pwm_symbol_sequencer
// Frame-level control for the PWM symbol decoder: qualifies pulses on the
// baseband sample stream, gates the decoder counter, waits out the decoder
// latency, captures each decoded symbol and hands it downstream on a
// valid/ready interface. All outputs come straight from flops.
module pwm_symbol_sequencer #(
  parameter int FRAME_LEN   = 4,
  parameter int MIN_GAP     = 4,
  parameter int MAX_WIDTH   = 255,
  parameter int DEC_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] ref_in,
  input  logic [15:0] data_in,
  input  logic [7:0]  decoded_symbol,
  output logic        enable_counter,
  output logic        counter_clear,
  output logic [7:0]  sym_out,
  output logic        sym_valid,
  input  logic        sym_ready,
  output logic [7:0]  sym_index,
  output logic        frame_done,
  output logic        timeout_err,
  output logic        busy
);

  localparam logic [7:0]  LAST_IDX_C  = 8'(FRAME_LEN - 1);
  localparam logic [7:0]  MIN_GAP_C   = 8'(MIN_GAP);
  localparam logic [15:0] MAX_WIDTH_C = 16'(MAX_WIDTH);
  localparam logic [3:0]  LAT_LAST_C  = 4'(DEC_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ARM    = 3'd2,
    COUNT  = 3'd3,
    LATCH  = 3'd4,
    OUTPUT = 3'd5
  } state_t;

  state_t      state_r, state_next_s;
  logic [15:0] data_q_r;
  logic [7:0]  gap_cnt_r, gap_cnt_next_s;
  logic [15:0] width_cnt_r, width_cnt_next_s;
  logic [3:0]  wait_cnt_r, wait_cnt_next_s;
  logic [7:0]  sym_out_r, sym_out_next_s;
  logic [7:0]  sym_index_r, sym_index_next_s;
  logic        timeout_err_r, timeout_err_next_s;
  logic        frame_done_r, frame_done_next_s;
  logic        enable_counter_r, counter_clear_r, sym_valid_r, busy_r;
  logic        hi_s;

  // Signed threshold compare on the registered sample; equality counts as low.
  assign hi_s = ($signed(data_q_r) > $signed(ref_in));

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and datapath next values; everything holds unless a rule fires.
  always_comb begin
    state_next_s       = state_r;
    gap_cnt_next_s     = gap_cnt_r;
    width_cnt_next_s   = width_cnt_r;
    wait_cnt_next_s    = wait_cnt_r;
    sym_out_next_s     = sym_out_r;
    sym_index_next_s   = sym_index_r;
    timeout_err_next_s = timeout_err_r;
    frame_done_next_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          sym_index_next_s   = 8'd0;
          timeout_err_next_s = 1'b0;
          state_next_s       = CLEAR;
        end else begin
          state_next_s = IDLE;
        end
      end
      CLEAR: begin
        gap_cnt_next_s = 8'd0;
        state_next_s   = ARM;
      end
      ARM: begin
        if (!hi_s) begin
          if (gap_cnt_r < MIN_GAP_C) begin
            gap_cnt_next_s = gap_cnt_r + 8'd1;
          end else begin
            gap_cnt_next_s = gap_cnt_r;
          end
        end else if (gap_cnt_r == MIN_GAP_C) begin
          width_cnt_next_s = 16'd1;
          state_next_s     = COUNT;
        end else begin
          gap_cnt_next_s = 8'd0;
        end
      end
      COUNT: begin
        if (hi_s) begin
          if (width_cnt_r < MAX_WIDTH_C) begin
            width_cnt_next_s = width_cnt_r + 16'd1;
          end else begin
            // Pulse too long: abandon the frame, keep sym_index where it is.
            timeout_err_next_s = 1'b1;
            state_next_s       = IDLE;
          end
        end else begin
          wait_cnt_next_s = 4'd0;
          state_next_s    = LATCH;
        end
      end
      LATCH: begin
        wait_cnt_next_s = wait_cnt_r + 4'd1;
        if (wait_cnt_r == LAT_LAST_C) begin
          sym_out_next_s = decoded_symbol;
          state_next_s   = OUTPUT;
        end else begin
          state_next_s = LATCH;
        end
      end
      OUTPUT: begin
        if (sym_ready) begin
          if (sym_index_r == LAST_IDX_C) begin
            frame_done_next_s = 1'b1;
            state_next_s      = IDLE;
          end else begin
            sym_index_next_s = sym_index_r + 8'd1;
            state_next_s     = CLEAR;
          end
        end else begin
          state_next_s = OUTPUT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Datapath registers and flopped Moore outputs (decoded from next state so
  // they line up with the state register).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q_r         <= 16'd0;
      gap_cnt_r        <= 8'd0;
      width_cnt_r      <= 16'd0;
      wait_cnt_r       <= 4'd0;
      sym_out_r        <= 8'd0;
      sym_index_r      <= 8'd0;
      timeout_err_r    <= 1'b0;
      frame_done_r     <= 1'b0;
      enable_counter_r <= 1'b0;
      counter_clear_r  <= 1'b0;
      sym_valid_r      <= 1'b0;
      busy_r           <= 1'b0;
    end else begin
      data_q_r         <= data_in;
      gap_cnt_r        <= gap_cnt_next_s;
      width_cnt_r      <= width_cnt_next_s;
      wait_cnt_r       <= wait_cnt_next_s;
      sym_out_r        <= sym_out_next_s;
      sym_index_r      <= sym_index_next_s;
      timeout_err_r    <= timeout_err_next_s;
      frame_done_r     <= frame_done_next_s;
      enable_counter_r <= (state_next_s == COUNT);
      counter_clear_r  <= (state_next_s == CLEAR);
      sym_valid_r      <= (state_next_s == OUTPUT);
      busy_r           <= (state_next_s != IDLE);
    end
  end

  assign enable_counter = enable_counter_r;
  assign counter_clear  = counter_clear_r;
  assign sym_out        = sym_out_r;
  assign sym_valid      = sym_valid_r;
  assign sym_index      = sym_index_r;
  assign frame_done     = frame_done_r;
  assign timeout_err    = timeout_err_r;
  assign busy           = busy_r;

endmodule
